plab5_mcore_net_msg_to_mem_resp: RTL

PLAB5_MCORE_NET_MSG_TO_MEM_RESP -- requirements
Module: plab5_mcore_net_msg_to_mem_resp

---
 rtl/plab5_mcore_net_msg_to_mem_resp_pkg.sv | 29 ++
 rtl/plab5_mcore_net_resp_queue.sv | 57 +++++
 rtl/plab5_mcore_net_msg_to_mem_resp.sv | 87 ++++++++
 3 files changed

// File: rtl/plab5_mcore_net_msg_to_mem_resp_pkg.sv
// Shared message-layout helpers and queue state encoding for the net-to-memory
// response adapter.
package plab5_mcore_net_msg_to_mem_resp_pkg;

  localparam int unsigned c_mem_type_nbits = 3;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } queue_state_e;

  // Byte-length field is wide enough to name any byte count within one data word.
  function automatic int unsigned mem_len_nbits(input int unsigned md);
    return (md / 8 > 1) ? $clog2(md / 8) : 1;
  endfunction

  function automatic int unsigned mem_resp_msg_nbits(input int unsigned mo,
                                                     input int unsigned md);
    return c_mem_type_nbits + mo + mem_len_nbits(md) + md;
  endfunction

  function automatic int unsigned net_msg_nbits(input int unsigned np,
                                                input int unsigned no,
                                                input int unsigned ns);
    return 2 * ns + no + np;
  endfunction

endpackage

// File: rtl/plab5_mcore_net_resp_queue.sv
// Two-entry val/rdy FIFO with no bypass path; occupancy is tracked as a
// three-state machine alongside one-bit read/write pointers.
module plab5_mcore_net_resp_queue
  import plab5_mcore_net_msg_to_mem_resp_pkg::*;
#(
  parameter int unsigned p_msg_nbits = 45
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  output logic                   enq_rdy,
  input  logic [p_msg_nbits-1:0] enq_msg,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [p_msg_nbits-1:0] deq_msg
);

  queue_state_e           state;
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [p_msg_nbits-1:0] entries [2];
  logic                   do_enq;
  logic                   do_deq;

  // Ready only depends on occupancy, so a full queue never accepts even if a
  // dequeue happens in the same cycle.
  assign enq_rdy = reset && (state != Q_FULL);
  assign deq_val = (state != Q_EMPTY);
  assign deq_msg = entries[rd_ptr];
  assign do_enq  = enq_val && enq_rdy;
  assign do_deq  = deq_val && deq_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= Q_EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_enq) wr_ptr <= ~wr_ptr;
      if (do_deq) rd_ptr <= ~rd_ptr;
      case (state)
        Q_EMPTY: if (do_enq) state <= Q_ONE;
        Q_ONE: begin
          if (do_enq && !do_deq)      state <= Q_FULL;
          else if (!do_enq && do_deq) state <= Q_EMPTY;
        end
        Q_FULL:  if (do_deq) state <= Q_ONE;
        default: state <= Q_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) entries[wr_ptr] <= enq_msg;
  end

endmodule

// File: rtl/plab5_mcore_net_msg_to_mem_resp.sv
// Converts network messages addressed to this terminal back into memory
// responses, stripping the core id from the opaque field; misrouted ones are dropped.
module plab5_mcore_net_msg_to_mem_resp
  import plab5_mcore_net_msg_to_mem_resp_pkg::*;
#(
  parameter int unsigned p_net_dest          = 0,
  parameter int unsigned p_mem_opaque_nbits  = 8,
  parameter int unsigned p_mem_data_nbits    = 32,
  parameter int unsigned p_net_opaque_nbits  = 4,
  parameter int unsigned p_net_srcdest_nbits = 3,
  localparam int unsigned c_len_nbits = mem_len_nbits(p_mem_data_nbits),
  localparam int unsigned c_mem_nbits = mem_resp_msg_nbits(p_mem_opaque_nbits, p_mem_data_nbits),
  localparam int unsigned c_net_nbits = net_msg_nbits(c_mem_nbits, p_net_opaque_nbits, p_net_srcdest_nbits)
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [c_net_nbits-1:0] net_msg,
  input  logic                   net_val,
  output logic                   net_rdy,
  output logic [c_mem_nbits-1:0] mem_msg,
  output logic                   mem_val,
  input  logic                   mem_rdy,
  output logic                   misroute_err,
  output logic [7:0]             drop_count
);

  localparam int unsigned c_ns = p_net_srcdest_nbits;
  localparam int unsigned c_mo = p_mem_opaque_nbits;
  localparam logic [c_ns-1:0] c_dest = c_ns'(p_net_dest);

  logic [c_ns-1:0]               net_dest;
  logic [c_ns-1:0]               net_src;
  logic [p_net_opaque_nbits-1:0] net_opaque;
  logic [c_mem_nbits-1:0]        net_payload;

  assign {net_dest, net_src, net_opaque, net_payload} = net_msg;

  logic [c_mem_type_nbits-1:0] resp_type;
  logic [c_mo-1:0]             resp_opaque;
  logic [c_len_nbits-1:0]      resp_len;
  logic [p_mem_data_nbits-1:0] resp_data;

  assign {resp_type, resp_opaque, resp_len, resp_data} = net_payload;

  // The request side parked the core id in the top opaque bits; the memory
  // client expects them cleared.
  logic [c_mo-1:0]        clean_opaque;
  logic [c_mem_nbits-1:0] clean_msg;

  assign clean_opaque = {{c_ns{1'b0}}, resp_opaque[c_mo-c_ns-1:0]};
  assign clean_msg    = {resp_type, clean_opaque, resp_len, resp_data};

  logic unused_net_bits;
  assign unused_net_bits = ^{net_src, net_opaque, resp_opaque[c_mo-1 -: c_ns]};

  logic dest_match;
  logic enq_val;
  logic misroute_accept;

  assign dest_match      = (net_dest == c_dest);
  assign enq_val         = net_val && dest_match;
  assign misroute_accept = net_val && net_rdy && !dest_match;

  plab5_mcore_net_resp_queue #(
    .p_msg_nbits (c_mem_nbits)
  ) resp_queue (
    .clk     (clk),
    .reset   (reset),
    .enq_val (enq_val),
    .enq_rdy (net_rdy),
    .enq_msg (clean_msg),
    .deq_val (mem_val),
    .deq_rdy (mem_rdy),
    .deq_msg (mem_msg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misroute_err <= 1'b0;
      drop_count   <= 8'd0;
    end else if (misroute_accept) begin
      misroute_err <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

endmodule
